// File: rtl/isa_tx_pkg.sv
// rtl/isa_tx_pkg.sv - shared FSM encoding, beat count and CRC-8 helper for isa_tx_link
package isa_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_CRC
  } tx_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  function automatic int beats_for(input int lane_w);
    return 64 / lane_w;
  endfunction

  // MSB-first CRC-8, init 0, no reflection, no final XOR
  function automatic logic [7:0] crc8_64(input logic [63:0] word);
    logic [7:0] crc;
    crc = 8'h00;
    for (int i = 63; i >= 0; i--) begin
      if (crc[7] ^ word[i]) crc = {crc[6:0], 1'b0} ^ CRC8_POLY;
      else                  crc = {crc[6:0], 1'b0};
    end
    return crc;
  endfunction

endpackage

// File: rtl/isa_tx_fifo.sv
// rtl/isa_tx_fifo.sv - single-clock word FIFO with occupancy count
module isa_tx_fifo
  import isa_tx_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             I_rd_clk,
  input  logic             I_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge I_rd_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge I_rd_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/isa_tx_link.sv
// rtl/isa_tx_link.sv - buffers ISA decode words and serializes framed beats; ISA_TX_CRC8_EN adds a CRC beat
module isa_tx_link
  import isa_tx_pkg::*;
#(
  parameter int          LANE_W     = 16,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] SYNC_WORD  = 16'hA55A
) (
  input  logic              I_rd_clk,
  input  logic              I_rst_n,
  input  logic [63:0]       I_tx_data,
  input  logic              I_tx_en,
  output logic              O_tx_ready,
  output logic [LANE_W-1:0] O_link_data,
  output logic              O_link_valid,
  input  logic              I_link_ready,
  output logic [31:0]       O_frame_cnt,
  output logic              O_ovf,
  output logic              O_busy
);

  localparam int                BEATS     = beats_for(LANE_W);
  localparam int                CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LANE_W-1:0] SYNC_BEAT = LANE_W'(SYNC_WORD);
  localparam logic [3:0]        LAST_IDX  = 4'(BEATS - 1);

  tx_state_e     state;
  logic [63:0]   shift;
  logic [63:0]   shift_nx;
  logic [63:0]   fifo_dout;
  logic [3:0]    beat_idx;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] cnt_next;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          hs;
  logic          last_beat;
  logic          frame_end;
`ifdef ISA_TX_CRC8_EN
  logic [7:0]    crc;
`endif

  isa_tx_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .I_rd_clk (I_rd_clk),
    .I_rst_n  (I_rst_n),
    .push     (push),
    .din      (I_tx_data),
    .pop      (pop),
    .dout     (fifo_dout),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    push      = I_tx_en && !fifo_full;
    hs        = O_link_valid && I_link_ready;
    last_beat = (state == ST_DATA) && (beat_idx == LAST_IDX);
`ifdef ISA_TX_CRC8_EN
    frame_end = hs && (state == ST_CRC);
`else
    frame_end = hs && last_beat;
`endif
    // The next word is popped on the closing handshake so frames run back-to-back
    pop       = !fifo_empty && ((state == ST_IDLE) || frame_end);
    cnt_next  = fifo_count + CW'(push) - CW'(pop);
    shift_nx  = shift << LANE_W;
  end

  assign O_busy = (state != ST_IDLE) || !fifo_empty;

  // Ready looks at the next occupancy so one late strobe still finds a free slot
  always_ff @(posedge I_rd_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_tx_ready <= 1'b1;
      O_ovf      <= 1'b0;
    end else begin
      O_tx_ready <= (cnt_next <= CW'(FIFO_DEPTH - 2));
      if (I_tx_en && fifo_full) O_ovf <= 1'b1;
    end
  end

  always_ff @(posedge I_rd_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state        <= ST_IDLE;
      shift        <= '0;
      beat_idx     <= '0;
      O_link_data  <= '0;
      O_link_valid <= 1'b0;
      O_frame_cnt  <= '0;
`ifdef ISA_TX_CRC8_EN
      crc          <= '0;
`endif
    end else begin
      if (pop) begin
        shift <= fifo_dout;
`ifdef ISA_TX_CRC8_EN
        crc   <= crc8_64(fifo_dout);
`endif
      end
      if (frame_end) begin
        O_frame_cnt <= O_frame_cnt + 32'd1;
        if (!fifo_empty) begin
          state       <= ST_SYNC;
          O_link_data <= SYNC_BEAT;
        end else begin
          state        <= ST_IDLE;
          O_link_valid <= 1'b0;
        end
      end else begin
        case (state)
          ST_IDLE: if (!fifo_empty) state <= ST_SYNC;
          ST_SYNC: begin
            if (!O_link_valid) begin
              O_link_valid <= 1'b1;
              O_link_data  <= SYNC_BEAT;
            end else if (I_link_ready) begin
              O_link_data <= shift[63 -: LANE_W];
              beat_idx    <= '0;
              state       <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (hs) begin
`ifdef ISA_TX_CRC8_EN
              if (last_beat) begin
                O_link_data <= LANE_W'(crc);
                state       <= ST_CRC;
              end else
`endif
              begin
                shift       <= shift_nx;
                O_link_data <= shift_nx[63 -: LANE_W];
                beat_idx    <= beat_idx + 4'd1;
              end
            end
          end
          ST_CRC: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_isa_tx_link.sv
// tb/tb_isa_tx_link.sv - self-checking bench for isa_tx_link (16-bit and 8-bit lane instances)
module tb_isa_tx_link;

  localparam logic [15:0] SYNC = 16'hA55A;
`ifdef ISA_TX_CRC8_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LEN16 = 4 + 1 + EXTRA;
  localparam int LEN8  = 8 + 1 + EXTRA;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] tx_data, tx_data8;
  logic        tx_en, tx_en8, link_ready, link_ready8;
  logic        tx_ready, tx_ready8, link_valid, link_valid8;
  logic        ovf, ovf8, busy, busy8;
  logic [15:0] link_data;
  logic [7:0]  link_data8;
  logic [31:0] frame_cnt, frame_cnt8;

  always #5 clk = ~clk;

  isa_tx_link dut (
    .I_rd_clk(clk), .I_rst_n(rst_n), .I_tx_data(tx_data), .I_tx_en(tx_en),
    .O_tx_ready(tx_ready), .O_link_data(link_data), .O_link_valid(link_valid),
    .I_link_ready(link_ready), .O_frame_cnt(frame_cnt), .O_ovf(ovf), .O_busy(busy)
  );

  isa_tx_link #(.LANE_W(8)) dut8 (
    .I_rd_clk(clk), .I_rst_n(rst_n), .I_tx_data(tx_data8), .I_tx_en(tx_en8),
    .O_tx_ready(tx_ready8), .O_link_data(link_data8), .O_link_valid(link_valid8),
    .I_link_ready(link_ready8), .O_frame_cnt(frame_cnt8), .O_ovf(ovf8), .O_busy(busy8)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  int          exp_frames = 0;
  logic [63:0] got16[$], got8[$], exp16[$], exp8[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference CRC: remainder of (word * x^8) divided by x^8+x^2+x+1
  function automatic logic [7:0] ref_crc(input logic [63:0] w);
    logic [71:0] r;
    r = {w, 8'h00};
    for (int i = 71; i >= 8; i--)
      if (r[i]) r = r ^ (72'h107 << (i - 8));
    return r[7:0];
  endfunction

  function automatic void add_frame(input logic [63:0] w, input int lw);
    logic [63:0] mask;
    logic [63:0] q[$];
    mask = (lw == 64) ? '1 : ((64'd1 << lw) - 64'd1);
    q.push_back({48'h0, SYNC} & mask);
    for (int k = 0; k < 64 / lw; k++) q.push_back((w >> (64 - lw * (k + 1))) & mask);
`ifdef ISA_TX_CRC8_EN
    q.push_back({56'h0, ref_crc(w)});
`endif
    foreach (q[k]) begin
      if (lw == 8) exp8.push_back(q[k]);
      else         exp16.push_back(q[k]);
    end
  endfunction

  function automatic logic [63:0] gb16(input int k);
    return (k < got16.size()) ? got16[k] : 64'hBAD0_BAD0_BAD0_BAD0;
  endfunction

  function automatic logic [63:0] gb8(input int k);
    return (k < got8.size()) ? got8[k] : 64'hBAD0_BAD0_BAD0_BAD0;
  endfunction

  task automatic compare16(input string name);
    chk({name, "_len"}, 64'(got16.size()), 64'(exp16.size()));
    for (int k = 0; k < exp16.size(); k++) chk($sformatf("%s[%0d]", name, k), gb16(k), exp16[k]);
  endtask

  // Link monitors: record handshaken beats and check hold rules while stalled
  logic        pv16 = 1'b0, pr16 = 1'b0, pv8 = 1'b0, pr8 = 1'b0;
  logic [15:0] pd16 = '0;
  logic [7:0]  pd8 = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv16 = 1'b0;
      pv8  = 1'b0;
    end else begin
      if (pv16 && !pr16) begin
        chk("hold_valid16", 64'(link_valid), 64'd1);
        chk("hold_data16", 64'(link_data), 64'(pd16));
      end
      if (pv8 && !pr8) begin
        chk("hold_valid8", 64'(link_valid8), 64'd1);
        chk("hold_data8", 64'(link_data8), 64'(pd8));
      end
      if (link_valid && link_ready)   got16.push_back(64'(link_data));
      if (link_valid8 && link_ready8) got8.push_back(64'(link_data8));
      pv16 = link_valid;  pr16 = link_ready;  pd16 = link_data;
      pv8  = link_valid8; pr8  = link_ready8; pd8  = link_data8;
    end
  end

  task automatic strobe(input logic [63:0] w);
    tx_data = w;
    tx_en   = 1'b1;
    tick();
    tx_en   = 1'b0;
  endtask

  // mode 0: ready held high, 1: ready toggles each cycle, 2: random ready
  task automatic run_until_idle(input int mode, input int n_beats, output int gaps);
    int cyc;
    cyc  = 0;
    gaps = 0;
    while ((got16.size() < n_beats || busy) && cyc < 2000) begin
      case (mode)
        0:       link_ready = 1'b1;
        1:       link_ready = ~link_ready;
        default: link_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      cyc++;
      if (got16.size() < n_beats && !link_valid) gaps++;
    end
    chk("run_timeout", 64'(cyc >= 2000), 64'd0);
  endtask

  typedef struct packed {
    logic [63:0] word;
    logic [1:0]  rmode;
    logic [15:0] b0, b1, b2, b3;
  } vec_t;

  vec_t        vt[4];
  logic [63:0] w;
  int          gaps, held, sent, cyc;

  initial begin
    vt[0] = '{64'h02001000_00000005, 2'd0, 16'h0200, 16'h1000, 16'h0000, 16'h0005};
    vt[1] = '{64'h00000000_00000000, 2'd1, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vt[2] = '{64'hFFFFFFFF_FFFFFFFF, 2'd2, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vt[3] = '{64'hDEADBEEF_CAFEF00D, 2'd1, 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D};

    tx_en = 0; tx_data = 0; link_ready = 0;
    tx_en8 = 0; tx_data8 = 0; link_ready8 = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(link_valid), 64'd0);
    chk("rst_data", 64'(link_data), 64'd0);
    chk("rst_ready", 64'(tx_ready), 64'd1);
    chk("rst_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready8", 64'(tx_ready8), 64'd1);
    rst_n = 1;
    tick();

    // Table vectors: one word per frame under different ready patterns
    for (int i = 0; i < 4; i++) begin
      got16.delete();
      exp16.delete();
      link_ready = 1'b1;
      strobe(vt[i].word);
      add_frame(vt[i].word, 16);
      if (i == 0) begin
        tick();
        chk("lat_n1_valid", 64'(link_valid), 64'd0);
        tick();
        chk("lat_n2_valid", 64'(link_valid), 64'd1);
        chk("lat_n2_sync", 64'(link_data), 64'(SYNC));
      end
      run_until_idle(int'(vt[i].rmode), LEN16, gaps);
      chk($sformatf("v%0d_sync", i), gb16(0), 64'(SYNC));
      chk($sformatf("v%0d_b0", i), gb16(1), 64'(vt[i].b0));
      chk($sformatf("v%0d_b1", i), gb16(2), 64'(vt[i].b1));
      chk($sformatf("v%0d_b2", i), gb16(3), 64'(vt[i].b2));
      chk($sformatf("v%0d_b3", i), gb16(4), 64'(vt[i].b3));
`ifdef ISA_TX_CRC8_EN
      chk($sformatf("v%0d_crc", i), gb16(5), 64'(ref_crc(vt[i].word)));
      if (vt[i].word == 64'h0) chk("crc_zero", gb16(5), 64'h0);
`endif
      compare16($sformatf("v%0d", i));
      exp_frames++;
      chk($sformatf("v%0d_cnt", i), 64'(frame_cnt), 64'(exp_frames));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
    end

    // Stalled link: fill the FIFO, overflow on the tenth strobe, then drain back-to-back
    got16.delete();
    exp16.delete();
    link_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      w = {32'h1000_0000 + 32'(i), 32'hABCD_0000 + 32'(i)};
      strobe(w);
      if (i < 9) add_frame(w, 16);
      held = (i == 0) ? 1 : ((i > 8) ? 8 : i);
      chk($sformatf("fill%0d_ready", i), 64'(tx_ready), 64'(held <= 6));
      chk($sformatf("fill%0d_ovf", i), 64'(ovf), 64'(i == 9));
    end
    run_until_idle(0, 9 * LEN16, gaps);
    chk("drain_gaps", 64'(gaps), 64'd0);
    compare16("drain");
    exp_frames += 9;
    chk("drain_cnt", 64'(frame_cnt), 64'(exp_frames));
    chk("drain_ovf_sticky", 64'(ovf), 64'd1);

    // 8-bit lane: truncated sync and MSB byte first
    got8.delete();
    exp8.delete();
    link_ready8 = 1'b1;
    tx_data8 = 64'h01234567_89ABCDEF;
    tx_en8 = 1'b1;
    tick();
    tx_en8 = 1'b0;
    add_frame(64'h01234567_89ABCDEF, 8);
    cyc = 0;
    while ((got8.size() < LEN8 || busy8) && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("l8_timeout", 64'(cyc >= 200), 64'd0);
    chk("l8_len", 64'(got8.size()), 64'(LEN8));
    chk("l8_sync", gb8(0), 64'h5A);
    chk("l8_first", gb8(1), 64'h01);
    chk("l8_last", gb8(8), 64'hEF);
    for (int k = 0; k < exp8.size(); k++) chk($sformatf("l8[%0d]", k), gb8(k), exp8[k]);
    chk("l8_cnt", 64'(frame_cnt8), 64'd1);

    // Reset while the third data beat is on the link
    got16.delete();
    link_ready = 1'b1;
    strobe(64'h11112222_33334444);
    strobe(64'h55556666_77778888);
    cyc = 0;
    while (got16.size() < 3 && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("mid_beat2", 64'(link_data), 64'h3333);
    chk("mid_valid", 64'(link_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(link_valid), 64'd0);
    chk("mid_rst_cnt", 64'(frame_cnt), 64'd0);
    chk("mid_rst_ovf", 64'(ovf), 64'd0);
    tick();
    rst_n = 1'b1;
    exp_frames = 0;
    repeat (3) tick();
    chk("post_rst_ready", 64'(tx_ready), 64'd1);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_valid", 64'(link_valid), 64'd0);

    // Random words and random back-pressure, writer obeys tx_ready
    got16.delete();
    exp16.delete();
    sent = 0;
    cyc = 0;
    while ((sent < 30 || got16.size() < exp16.size() || busy) && cyc < 5000) begin
      link_ready = ($urandom_range(0, 3) != 0);
      if (sent < 30 && tx_ready && $urandom_range(0, 1) == 1) begin
        w = {$urandom, $urandom};
        tx_data = w;
        tx_en = 1'b1;
        add_frame(w, 16);
        sent++;
      end else begin
        tx_en = 1'b0;
      end
      tick();
      cyc++;
    end
    tx_en = 1'b0;
    chk("rnd_timeout", 64'(cyc >= 5000), 64'd0);
    compare16("rnd");
    exp_frames += 30;
    chk("rnd_cnt", 64'(frame_cnt), 64'(exp_frames));
    chk("rnd_ovf", 64'(ovf), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
